// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mmio_uart_tx
// Brief   : MMIO-mapped 8N1 UART transmitter with TX FIFO and status polling.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter logic [29:0] BASE_ADDR  = 30'h0400_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_mmio_addr,
  input  logic [31:0] i_mmio_data,
  input  logic [3:0]  i_mmio_mask,
  input  logic        i_mmio_wren,
  output logic [31:0] o_mmio_data,
  output logic        o_tx
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [15:0]   DIV_RST  = CLK_DIV[15:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic        hit;
  logic [1:0]  offset;
  logic        wr_txdata, wr_div;
  logic [15:0] divisor;

  assign hit       = (i_mmio_addr[29:2] == BASE_ADDR[29:2]);
  assign offset    = i_mmio_addr[1:0];
  assign wr_txdata = i_mmio_wren && hit && (offset == 2'd0) && i_mmio_mask[0];
  assign wr_div    = i_mmio_wren && hit && (offset == 2'd2);

  // Only byte lanes 0/1 of the data bus have a destination.
  logic unused_bits;
  assign unused_bits = ^{i_mmio_data[31:16], i_mmio_mask[3:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= DIV_RST;
    end else if (wr_div) begin
      if (i_mmio_mask[0]) divisor[7:0]  <= i_mmio_data[7:0];
      if (i_mmio_mask[1]) divisor[15:8] <= i_mmio_data[15:8];
    end
  end

  // TX FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is lost.
  assign push  = wr_txdata && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_mmio_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serializer
  state_t      state, state_n;
  logic [7:0]  shift, shift_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [15:0] period_cnt, period_len;
  logic        tx, tx_n, load, period_end;

  assign period_end = (period_cnt == period_len - 16'd1);

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    tx_n      = tx;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (period_end) begin
          bit_cnt_n = 3'd0;
          tx_n      = shift[0];
          load      = 1'b1;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (period_end) begin
          load = 1'b1;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shift_n   = shift >> 1;
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        if (period_end) begin
          // Chain straight into the next frame when more data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            load    = 1'b1;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
      period_cnt <= '0;
      period_len <= 16'd1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      tx      <= tx_n;
      // Divisor is latched per bit period so mid-frame writes apply later.
      if (load) begin
        period_len <= (divisor == 16'd0) ? 16'd1 : divisor;
        period_cnt <= '0;
      end else if (state != IDLE) begin
        period_cnt <= period_cnt + 16'd1;
      end
    end
  end

  assign o_tx = tx;

  // Register read path
  logic [3:0] count_field;
  if (AW + 1 < 4) begin : g_cnt_narrow
    assign count_field = {{(3 - AW){1'b0}}, count};
  end else begin : g_cnt_wide
    assign count_field = count[3:0];
  end

  always_comb begin
    o_mmio_data = '0;
    if (hit) begin
      case (offset)
        2'd1:    o_mmio_data = {20'd0, count_field, 5'd0, (state != IDLE), empty, full};
        2'd2:    o_mmio_data = {16'd0, divisor};
        default: o_mmio_data = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_mmio_uart_tx
// Brief   : Directed + randomized bench for mmio_uart_tx against a frame model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

  localparam int          DEPTH   = 8;
  localparam logic [29:0] A_TXD   = 30'h0400_0000;
  localparam logic [29:0] A_STAT  = 30'h0400_0001;
  localparam logic [29:0] A_DIV   = 30'h0400_0002;
  localparam logic [29:0] A_RSV   = 30'h0400_0003;
  localparam logic [29:0] A_MISS  = 30'h0400_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        wren;
  logic [31:0] rdata;
  logic        tx;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  logic tx_log [0:65535];

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR (30'h0400_0000),
    .CLK_DIV   (16),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_mmio_addr(addr),
    .i_mmio_data(wdata),
    .i_mmio_mask(mask),
    .i_mmio_wren(wren),
    .o_mmio_data(rdata),
    .o_tx       (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Every clock advance goes through here so o_tx is logged once per cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    if (cycle < 65536) tx_log[cycle] = tx;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; mask = m; wren = 1'b1;
    cyc();
    wren = 1'b0; addr = '0; wdata = '0; mask = '0;
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k, input int p);
    int slot;
    slot = k / p;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Writes n bytes on consecutive cycles from idle and checks FIFO status and
  // the resulting serial waveform against an occupancy/frame-timing model.
  task automatic run_burst(input string tag, input int div, input int n,
                           input logic [7:0] bytes [10]);
    logic [31:0] r;
    logic [7:0]  q[$];
    int p, c0, occ, next_pop, total, bad;
    bit popnow, fullb, busy_m;

    wr(A_DIV, div, 4'b0011);
    cyc();
    p = (div == 0) ? 1 : div;
    c0 = 0;
    for (int i = 0; i < n; i++) begin
      wr(A_TXD, {24'd0, bytes[i]}, 4'b0001);
      if (i == 0) c0 = cycle;
    end

    occ = 0; next_pop = 1; busy_m = 1'b0;
    for (int e = 0; e < n; e++) begin
      fullb  = (occ == DEPTH);
      popnow = (e == next_pop) && (occ > 0);
      if (!fullb) begin q.push_back(bytes[e]); occ++; end
      if (popnow) begin occ--; next_pop += 10 * p; busy_m = 1'b1; end
    end
    rd(A_STAT, r);
    check({tag, "_status"}, r, {20'd0, 4'(occ), 5'd0, busy_m, (occ == 0), (occ == DEPTH)});

    total = q.size() * 10 * p;
    while (cycle < c0 + total + 2) begin
      cyc();
      if (cycle == c0 + total) begin
        rd(A_STAT, r); check({tag, "_busy_last"}, {31'd0, r[2]}, 32'd1);
      end else if (cycle == c0 + total + 1) begin
        rd(A_STAT, r); check({tag, "_busy_clear"}, {31'd0, r[2]}, 32'd0);
      end
    end

    check({tag, "_pre_start"}, {31'd0, tx_log[c0]}, 32'd1);
    for (int f = 0; f < q.size(); f++) begin
      bad = 0;
      for (int k = 0; k < 10 * p; k++)
        if (tx_log[c0 + 1 + f*10*p + k] !== exp_bit(q[f], k, p)) bad++;
      check($sformatf("%s_frame%0d_badcycles", tag, f), bad, 32'd0);
    end
    check({tag, "_idle_after"}, {31'd0, tx_log[c0 + total + 1]}, 32'd1);
    rd(A_STAT, r);
    check({tag, "_status_end"}, r, 32'h0000_0002);
  endtask

  initial begin : main
    logic [31:0] r;
    logic [7:0]  b [10];
    int c0, lows;

    rst = 1'b1; addr = '0; wdata = '0; mask = '0; wren = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    rd(A_STAT, r); check("reset_status", r, 32'h0000_0002);
    rd(A_DIV, r);  check("reset_div", r, 32'h0000_0010);
    check("reset_tx", {31'd0, tx}, 32'd1);

    // Decode and byte-lane behaviour
    wr(A_TXD, 32'h0000_00FF, 4'b1110);
    cyc();
    rd(A_STAT, r); check("mask_nopush_status", r, 32'h0000_0002);
    check("mask_nopush_tx", {31'd0, tx}, 32'd1);
    wr(A_MISS, 32'hDEAD_BEEF, 4'b1111);
    rd(A_MISS, r); check("miss_read", r, 32'd0);
    rd(A_STAT, r); check("miss_status", r, 32'h0000_0002);
    rd(A_DIV, r);  check("miss_div", r, 32'h0000_0010);
    wr(A_RSV, 32'hFFFF_FFFF, 4'b1111);
    rd(A_RSV, r);  check("rsv_read", r, 32'd0);
    rd(A_TXD, r);  check("txdata_read", r, 32'd0);
    wr(A_DIV, 32'h0000_1234, 4'b0001);
    rd(A_DIV, r);  check("div_lane0", r, 32'h0000_0034);
    wr(A_DIV, 32'h0000_1234, 4'b0010);
    rd(A_DIV, r);  check("div_lane1", r, 32'h0000_1234);

    b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_burst("single", 4, 1, b);
    b = '{8'h55, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_burst("b2b", 4, 2, b);
    for (int i = 0; i < 10; i++) b[i] = 8'(i);
    run_burst("overflow", 16, 10, b);

    for (int round = 0; round < 5; round++) begin
      for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
      run_burst($sformatf("rand%0d", round), int'($urandom_range(0, 5)),
                int'($urandom_range(1, 10)), b);
    end

    // Reset in the middle of DATA bit 3 with a second byte still queued
    wr(A_DIV, 32'd4, 4'b0011);
    wr(A_TXD, 32'h0000_00F0, 4'b0001);
    c0 = cycle;
    wr(A_TXD, 32'h0000_0033, 4'b0001);
    while (cycle < c0 + 18) cyc();
    check("midrst_bit3_before", {31'd0, tx_log[c0 + 18]}, {31'd0, exp_bit(8'hF0, 17, 4)});
    rst = 1'b1;
    cyc();
    check("midrst_tx_high", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    rd(A_STAT, r); check("midrst_status", r, 32'h0000_0002);
    rd(A_DIV, r);  check("midrst_div", r, 32'h0000_0010);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (tx !== 1'b1) lows++;
    end
    check("midrst_no_frame", lows, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
